// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } hazard_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module hazard_unit_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller: load-use bubbles, dcache waits, redirect squashes and halt drain.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memread,
  input  logic             exmem_dmemreq,
  input  logic             exmem_redir,
  input  logic             memwb_halt,
  input  logic             ihit,
  input  logic             dhit,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] loaduse_cnt,
  output logic [CNT_W-1:0] redir_cnt
);

  hazard_state_t r_state;
  hazard_state_t w_next;
  logic          w_loaduse;
  logic          w_frozen;
  logic          w_active;
  logic          w_stall_inc;
  logic          w_loaduse_inc;
  logic          w_redir_inc;

  always_comb begin
    w_next        = r_state;
    w_loaduse     = idex_memread && (idex_rd != REG_ZERO) &&
                    ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));
    w_active      = (r_state != HALT);
    // In DWAIT the request is assumed held; only dhit releases the pipe.
    w_frozen      = (r_state == DWAIT) ? !dhit
                                       : ((r_state == RUN) && exmem_dmemreq && !dhit);
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    idex_en       = 1'b0;
    exmem_en      = 1'b0;
    memwb_en      = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;

    if (w_active && !w_frozen) begin
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      idex_en  = 1'b1;
      if (exmem_redir) begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (w_loaduse || !ihit) begin
        idex_flush = 1'b1;
      end else begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
      end
    end

    unique case (r_state)
      RUN:     w_next = memwb_halt ? HALT : (w_frozen ? DWAIT : RUN);
      DWAIT:   w_next = memwb_halt ? HALT : (dhit ? RUN : DWAIT);
      HALT:    w_next = HALT;
      default: w_next = RUN;
    endcase

    w_stall_inc   = w_active && !pc_en;
    w_redir_inc   = w_active && !w_frozen && exmem_redir;
    w_loaduse_inc = w_active && !w_frozen && !exmem_redir && w_loaduse;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  assign halt = (r_state == HALT);

  hazard_unit_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  hazard_unit_sat_counter #(.CNT_W(CNT_W)) u_loaduse_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (w_loaduse_inc),
    .count (loaduse_cnt)
  );

  hazard_unit_sat_counter #(.CNT_W(CNT_W)) u_redir_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (w_redir_inc),
    .count (redir_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed plus randomized checks of hazard_unit against a behavioural model.
module tb_hazard_unit;

  localparam int CNT_W = 4;
  localparam int MAXC  = 15;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [4:0]       ifid_rs, ifid_rt, idex_rd;
  logic             idex_memread, exmem_dmemreq, exmem_redir, memwb_halt, ihit, dhit;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush, halt;
  logic [CNT_W-1:0] stall_cnt, loaduse_cnt, redir_cnt;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .ifid_rs       (ifid_rs),
    .ifid_rt       (ifid_rt),
    .idex_rd       (idex_rd),
    .idex_memread  (idex_memread),
    .exmem_dmemreq (exmem_dmemreq),
    .exmem_redir   (exmem_redir),
    .memwb_halt    (memwb_halt),
    .ihit          (ihit),
    .dhit          (dhit),
    .pc_en         (pc_en),
    .ifid_en       (ifid_en),
    .idex_en       (idex_en),
    .exmem_en      (exmem_en),
    .memwb_en      (memwb_en),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .exmem_flush   (exmem_flush),
    .halt          (halt),
    .stall_cnt     (stall_cnt),
    .loaduse_cnt   (loaduse_cnt),
    .redir_cnt     (redir_cnt)
  );

  always #5 CLK = ~CLK;

  // Model: 0 = running, 1 = waiting on dcache, 2 = halted.
  int m_mode;
  int m_stall, m_lu, m_rd;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_stall = 0;
    m_lu    = 0;
    m_rd    = 0;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  // One cycle: drive, check combinational outputs, clock, check counters.
  task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic mr, input logic dreq, input logic dh,
                      input logic rdr, input logic mh, input logic ih);
    bit       halted, frozen, lu;
    bit [7:0] exp;
    ifid_rs = rs; ifid_rt = rt; idex_rd = rd; idex_memread = mr; exmem_dmemreq = dreq;
    dhit = dh; exmem_redir = rdr; memwb_halt = mh; ihit = ih;
    #1;
    halted = (m_mode == 2);
    frozen = !halted && ((m_mode == 1) ? !dh : (dreq && !dh));
    lu     = mr && (rd != 0) && (rd == rs || rd == rt);
    // Order: pc, ifid, idex, exmem, memwb enables; ifid, idex, exmem flushes.
    if (halted || frozen) exp = 8'b00000_000;
    else if (rdr)         exp = 8'b11111_111;
    else if (lu || !ih)   exp = 8'b00111_010;
    else                  exp = 8'b11111_000;
    chk({tag, ":ctl"}, {24'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                        ifid_flush, idex_flush, exmem_flush}, {24'd0, exp});
    chk({tag, ":halt"}, {31'd0, halt}, {31'd0, halted});
    @(posedge CLK);
    if (!halted) begin
      if (!exp[7]) m_stall = sat_inc(m_stall);
      if (!frozen && rdr) m_rd = sat_inc(m_rd);
      else if (!frozen && lu) m_lu = sat_inc(m_lu);
      if (mh)               m_mode = 2;
      else if (m_mode == 1) m_mode = dh ? 0 : 1;
      else                  m_mode = frozen ? 1 : 0;
    end
    #1;
    chk({tag, ":stall_cnt"}, {28'd0, stall_cnt}, m_stall);
    chk({tag, ":loaduse_cnt"}, {28'd0, loaduse_cnt}, m_lu);
    chk({tag, ":redir_cnt"}, {28'd0, redir_cnt}, m_rd);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    ifid_rs = '0; ifid_rt = '0; idex_rd = '0; idex_memread = 0; exmem_dmemreq = 0;
    exmem_redir = 0; memwb_halt = 0; ihit = 1; dhit = 0;
    do_reset();
    chk("rst:counters", {20'd0, stall_cnt, loaduse_cnt, redir_cnt}, 32'd0);
    step("normal", 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 1);

    // Load-use: exactly one bubble, then rd=0 does not stall.
    step("lu", 5'd5, 5'd7, 5'd5, 1, 0, 0, 0, 0, 1);
    chk("lu:count_one", {28'd0, loaduse_cnt}, 32'd1);
    step("lu_rt", 5'd9, 5'd6, 5'd6, 1, 0, 0, 0, 0, 1);
    step("lu_r0", 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 1);
    chk("lu_r0:pc_en", {31'd0, pc_en}, 32'd1);

    // Dcache wait for 4 cycles then hit.
    do_reset();
    for (int i = 0; i < 4; i++) step("dwait", 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, 0, 1);
    chk("dwait:stall4", {28'd0, stall_cnt}, 32'd4);
    step("dwait_hit", 5'd1, 5'd2, 5'd3, 0, 1, 1, 0, 0, 1);
    step("after_hit", 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 1);
    step("req_hit_same", 5'd1, 5'd2, 5'd3, 0, 1, 1, 0, 0, 1);

    // Async reset in the middle of DWAIT.
    step("pre_rst", 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, 0, 1);
    step("pre_rst2", 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, 0, 1);
    #2;
    nRST = 1'b0;
    exmem_dmemreq = 0;
    #1;
    model_reset();
    chk("async_rst:cnt", {20'd0, stall_cnt, loaduse_cnt, redir_cnt}, 32'd0);
    chk("async_rst:halt", {31'd0, halt}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    step("post_rst", 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 1);

    // Redirect overrides load-use and missing ihit.
    do_reset();
    step("redir", 5'd5, 5'd1, 5'd5, 1, 0, 0, 1, 0, 0);
    chk("redir:cnt1", {28'd0, redir_cnt}, 32'd1);
    chk("redir:lu0", {28'd0, loaduse_cnt}, 32'd0);

    // Halt together with dwait, then held for 100 cycles under random input.
    step("halt_dwait", 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, 1, 1);
    for (int i = 0; i < 100; i++) begin
      step("halted", 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    chk("halt:held", {31'd0, halt}, 32'd1);

    // Saturation of the 4-bit stall counter.
    do_reset();
    for (int i = 0; i < 20; i++) step("sat", 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 0);
    chk("sat:stall15", {28'd0, stall_cnt}, 32'd15);

    // Randomized traffic with small register numbers to provoke hazards.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 120; i++) begin
        step("rand", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 2) == 0),
             1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 90) == 0),
             ($urandom_range(0, 3) != 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
